// File: rtl/vout_req_pkg.sv
// Shared types and constants for the display read-request generator.
package vout_req_pkg;

  localparam int IDX_W           = 2;
  localparam int CNT_W           = 16;
  localparam int ACK_TIMEOUT_DEF = 4095;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_READ = 2'd2
  } state_e;

  // The writer is filling idx, so the newest complete frame sits one behind it.
  function automatic logic [IDX_W-1:0] last_done_idx(input logic [IDX_W-1:0] idx);
    return idx - 2'd1;
  endfunction

endpackage

// File: rtl/vsync_edge_det.sv
// Three-flop synchroniser for vsync with a one-cycle rising-edge pulse.
module vsync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);

  logic d0_q, d1_q, d2_q;

  // Synchroniser chain; d2 only serves as the delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0_q <= 1'b0;
      d1_q <= 1'b0;
      d2_q <= 1'b0;
    end else begin
      d0_q <= async_i;
      d1_q <= d0_q;
      d2_q <= d1_q;
    end
  end

  assign rise_o = d1_q & ~d2_q;

endmodule

// File: rtl/vout_read_req_gen.sv
// Issues one frame read request per display vsync, pointing the reader at the
// most recently completed buffer, with ack timeout and repeat/overrun flags.
//
// state | meaning
// IDLE  | waiting for vsync rising edge
// REQ   | read_req asserted, waiting for ack (timeout counter running)
// READ  | reader busy with the frame, waiting for read_done
module vout_read_req_gen
  import vout_req_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             vout_vsync,
  input  logic [IDX_W-1:0] wr_addr_index,
  output logic             read_req,
  output logic [IDX_W-1:0] read_addr_index,
  input  logic             read_req_ack,
  input  logic             read_done,
  output logic             frame_repeat,
  output logic             overrun,
  output logic [CNT_W-1:0] repeat_cnt,
  output logic             err_timeout,
  input  logic             err_clr
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic             vs_rise;
  logic [IDX_W-1:0] s0_q, s1_q, stable_q;
  logic [IDX_W-1:0] cand;

  state_e           state_q, state_d;
  logic             read_req_q, read_req_d;
  logic [IDX_W-1:0] addr_q, addr_d;
  logic [IDX_W-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_repeat_q, frame_repeat_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             err_q, err_d;
  logic             issue, err_set, rep_inc;

  vsync_edge_det u_vs_det (
    .clk    (pclk),
    .rst_n  (rst_n),
    .async_i(vout_vsync),
    .rise_o (vs_rise)
  );

  // Write index crosses as a 2-bit bus; only accept it once two samples agree.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q     <= '0;
      s1_q     <= '0;
      stable_q <= '0;
    end else begin
      s0_q <= wr_addr_index;
      s1_q <= s0_q;
      if (s0_q == s1_q) stable_q <= s1_q;
    end
  end

  assign cand = last_done_idx(stable_q);

  // State and output registers.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      read_req_q     <= 1'b0;
      addr_q         <= '0;
      prev_q         <= '0;
      cnt_q          <= '0;
      frame_repeat_q <= 1'b0;
      overrun_q      <= 1'b0;
      rcnt_q         <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      read_req_q     <= read_req_d;
      addr_q         <= addr_d;
      prev_q         <= prev_d;
      cnt_q          <= cnt_d;
      frame_repeat_q <= frame_repeat_d;
      overrun_q      <= overrun_d;
      rcnt_q         <= rcnt_d;
      err_q          <= err_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d        = state_q;
    read_req_d     = read_req_q;
    addr_d         = addr_q;
    prev_d         = prev_q;
    cnt_d          = cnt_q;
    frame_repeat_d = 1'b0;
    overrun_d      = 1'b0;
    rcnt_d         = rcnt_q;
    err_d          = err_q;
    issue          = 1'b0;
    err_set        = 1'b0;
    rep_inc        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (vs_rise) issue = 1'b1;
      end
      ST_REQ: begin
        if (vs_rise) overrun_d = 1'b1;
        // Ack is checked first so a last-cycle ack never reports a timeout.
        if (read_req_ack) begin
          read_req_d = 1'b0;
          state_d    = ST_READ;
        end else if (cnt_q == CNT_LAST) begin
          read_req_d = 1'b0;
          err_set    = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_READ: begin
        // A vsync landing on the finishing cycle is not an overrun: chain
        // straight into the next request.
        if (read_done) begin
          if (vs_rise) issue = 1'b1;
          else         state_d = ST_IDLE;
        end else if (vs_rise) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        read_req_d = 1'b0;
      end
    endcase

    if (issue) begin
      state_d    = ST_REQ;
      read_req_d = 1'b1;
      addr_d     = cand;
      prev_d     = cand;
      cnt_d      = '0;
      if (cand == prev_q) begin
        frame_repeat_d = 1'b1;
        rep_inc        = 1'b1;
      end
    end

    if (err_clr) begin
      err_d  = 1'b0;
      rcnt_d = '0;
    end else begin
      if (err_set) err_d = 1'b1;
      if (rep_inc && (rcnt_q != 16'hFFFF)) rcnt_d = rcnt_q + 16'd1;
    end
  end

  assign read_req        = read_req_q;
  assign read_addr_index = addr_q;
  assign frame_repeat    = frame_repeat_q;
  assign overrun         = overrun_q;
  assign repeat_cnt      = rcnt_q;
  assign err_timeout     = err_q;

endmodule

// File: tb/tb_vout_read_req_gen.sv
module tb_vout_read_req_gen;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic        vout_vsync;
  logic [1:0]  wr_addr_index;
  logic        read_req;
  logic [1:0]  read_addr_index;
  logic        read_req_ack;
  logic        read_done;
  logic        frame_repeat;
  logic        overrun;
  logic [15:0] repeat_cnt;
  logic        err_timeout;
  logic        err_clr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 pclk = ~pclk;

  vout_read_req_gen #(.ACK_TIMEOUT(8)) dut (
    .pclk           (pclk),
    .rst_n          (rst_n),
    .vout_vsync     (vout_vsync),
    .wr_addr_index  (wr_addr_index),
    .read_req       (read_req),
    .read_addr_index(read_addr_index),
    .read_req_ack   (read_req_ack),
    .read_done      (read_done),
    .frame_repeat   (frame_repeat),
    .overrun        (overrun),
    .repeat_cnt     (repeat_cnt),
    .err_timeout    (err_timeout),
    .err_clr        (err_clr)
  );

  typedef struct {
    logic        vs;
    logic [1:0]  wr;
    logic        ack;
    logic        done;
    logic        req;
    logic [1:0]  addr;
    logic        rep;
    logic        ovr;
    logic        err;
    logic [15:0] rcnt;
  } vec_t;

  vec_t tbl[33];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic start_vs;
    vout_vsync = 1'b0;
    tick;
    tick;
    vout_vsync = 1'b1;
  endtask

  task automatic wait_req;
    int n;
    n = 0;
    while (read_req !== 1'b1 && n < 6) begin
      tick;
      n++;
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " read_req"},     32'(read_req),        32'd0);
    chk({nm, " addr"},         32'(read_addr_index), 32'd0);
    chk({nm, " frame_repeat"}, 32'(frame_repeat),    32'd0);
    chk({nm, " overrun"},      32'(overrun),         32'd0);
    chk({nm, " repeat_cnt"},   32'(repeat_cnt),      32'd0);
    chk({nm, " err_timeout"},  32'(err_timeout),     32'd0);
  endtask

  initial begin
    int hi;
    logic seen;

    //          vs wr  ack done | req addr rep ovr err rcnt
    tbl[0]  = '{0, 2, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 2, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 2, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 2, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 2, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 2, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[6]  = '{1, 2, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[7]  = '{1, 2, 1, 0, 0, 1, 0, 0, 0, 0};
    tbl[8]  = '{0, 2, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[9]  = '{0, 2, 0, 1, 0, 1, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
    tbl[13] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[14] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[15] = '{1, 0, 0, 0, 1, 3, 0, 0, 0, 0};
    tbl[16] = '{1, 0, 1, 0, 0, 3, 0, 0, 0, 0};
    tbl[17] = '{0, 0, 0, 1, 0, 3, 0, 0, 0, 0};
    tbl[18] = '{1, 0, 0, 0, 0, 3, 0, 0, 0, 0};
    tbl[19] = '{1, 0, 0, 0, 0, 3, 0, 0, 0, 0};
    tbl[20] = '{1, 0, 0, 0, 1, 3, 1, 0, 0, 1};
    tbl[21] = '{1, 0, 1, 0, 0, 3, 0, 0, 0, 1};
    tbl[22] = '{0, 0, 0, 0, 0, 3, 0, 0, 0, 1};
    tbl[23] = '{1, 0, 0, 0, 0, 3, 0, 0, 0, 1};
    tbl[24] = '{1, 0, 0, 0, 0, 3, 0, 0, 0, 1};
    tbl[25] = '{1, 0, 0, 0, 0, 3, 0, 1, 0, 1};
    tbl[26] = '{1, 0, 0, 0, 0, 3, 0, 0, 0, 1};
    tbl[27] = '{0, 0, 0, 0, 0, 3, 0, 0, 0, 1};
    tbl[28] = '{1, 0, 0, 0, 0, 3, 0, 0, 0, 1};
    tbl[29] = '{1, 0, 0, 0, 0, 3, 0, 0, 0, 1};
    tbl[30] = '{1, 0, 0, 1, 1, 3, 1, 0, 0, 2};
    tbl[31] = '{1, 0, 1, 0, 0, 3, 0, 0, 0, 2};
    tbl[32] = '{0, 0, 0, 1, 0, 3, 0, 0, 0, 2};

    rst_n         = 1'b0;
    vout_vsync    = 1'b0;
    wr_addr_index = 2'd2;
    read_req_ack  = 1'b0;
    read_done     = 1'b0;
    err_clr       = 1'b0;

    repeat (3) tick;
    chk_all_zero("reset");

    @(negedge pclk);
    rst_n = 1'b1;

    for (int i = 0; i < 33; i++) begin
      vout_vsync    = tbl[i].vs;
      wr_addr_index = tbl[i].wr;
      read_req_ack  = tbl[i].ack;
      read_done     = tbl[i].done;
      tick;
      chk($sformatf("row%0d read_req", i),     32'(read_req),        32'(tbl[i].req));
      chk($sformatf("row%0d addr", i),         32'(read_addr_index), 32'(tbl[i].addr));
      chk($sformatf("row%0d frame_repeat", i), 32'(frame_repeat),    32'(tbl[i].rep));
      chk($sformatf("row%0d overrun", i),      32'(overrun),         32'(tbl[i].ovr));
      chk($sformatf("row%0d err_timeout", i),  32'(err_timeout),     32'(tbl[i].err));
      chk($sformatf("row%0d repeat_cnt", i),   32'(repeat_cnt),      32'(tbl[i].rcnt));
    end
    read_req_ack = 1'b0;
    read_done    = 1'b0;

    // Ack timeout: request must stay up exactly 8 cycles, then sticky error.
    start_vs;
    wait_req;
    chk("to rise",         32'(read_req),        32'd1);
    chk("to addr",         32'(read_addr_index), 32'd3);
    chk("to frame_repeat", 32'(frame_repeat),    32'd1);
    chk("to repeat_cnt",   32'(repeat_cnt),      32'd3);
    hi = 0;
    while (read_req === 1'b1 && hi < 20) begin
      hi++;
      tick;
    end
    chk("to req cycles",   32'(hi),          32'd8);
    chk("to err_timeout",  32'(err_timeout), 32'd1);
    tick;
    chk("to err sticky",   32'(err_timeout), 32'd1);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("clr err_timeout", 32'(err_timeout), 32'd0);
    chk("clr repeat_cnt",  32'(repeat_cnt),  32'd0);

    // Ack in the final cycle before timeout wins.
    start_vs;
    wait_req;
    chk("race rise",       32'(read_req),   32'd1);
    chk("race repeat_cnt", 32'(repeat_cnt), 32'd1);
    repeat (7) tick;
    chk("race still req",  32'(read_req),   32'd1);
    read_req_ack = 1'b1;
    tick;
    read_req_ack = 1'b0;
    chk("race read_req",    32'(read_req),    32'd0);
    chk("race err_timeout", 32'(err_timeout), 32'd0);
    tick;
    chk("race err later",   32'(err_timeout), 32'd0);

    // Still in READ: a new vsync only flags overrun.
    start_vs;
    seen = 1'b0;
    repeat (4) begin
      tick;
      if (overrun === 1'b1) seen = 1'b1;
    end
    chk("read overrun seen", 32'(seen),     32'd1);
    chk("read no new req",   32'(read_req), 32'd0);
    read_done = 1'b1;
    tick;
    read_done = 1'b0;

    // Asynchronous reset in the middle of a request.
    start_vs;
    wait_req;
    chk("mid rise",         32'(read_req),     32'd1);
    chk("mid frame_repeat", 32'(frame_repeat), 32'd1);
    chk("mid repeat_cnt",   32'(repeat_cnt),   32'd2);
    #2;
    rst_n      = 1'b0;
    vout_vsync = 1'b0;
    #1;
    chk_all_zero("async rst");
    tick;
    tick;
    @(negedge pclk);
    rst_n = 1'b1;
    #1;
    chk_all_zero("release");
    tick;
    chk_all_zero("post release");

    start_vs;
    wait_req;
    chk("fresh rise",         32'(read_req),        32'd1);
    chk("fresh addr",         32'(read_addr_index), 32'd3);
    chk("fresh frame_repeat", 32'(frame_repeat),    32'd0);
    chk("fresh repeat_cnt",   32'(repeat_cnt),      32'd0);
    read_req_ack = 1'b1;
    tick;
    read_req_ack = 1'b0;
    chk("fresh ack drop", 32'(read_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
